scan_controller: RTL and testbench

- Control FSM that sits directly upstream of two `counter` instances, an inner (column) counter and an outer (row) counter, and consumes their carry-outs.
- It sequences a full nested scan. It clears both counters, then for every index pair it issues a req/ack step to the datapath. It then advances the inner counter, and the outer counter on inner wrap.
- It finishes when both counters wrap together, and includes abort and an ack watchdog.

---
 rtl/scan_controller.sv | 131 +++++++++++++
 tb/tb_scan_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : scan_controller
// Purpose  : Sequences a nested row/column scan over two external counters.
//            Clears both counters, then runs a req/ack handshake per index pair.
//            After each pair it advances the inner counter, and the outer
//            counter when the inner one wraps. It finishes when both
//            carry-outs are high together. Supports abort and an ack watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module scan_controller #(
  parameter int TW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic step_ack,
  input  logic co_i,
  input  logic co_o,
  output logic cnt_i,
  output logic clr_i,
  output logic cnt_o,
  output logic clr_o,
  output logic step_req,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_ADVANCE  = 3'd3,
    S_FINISH   = 3'd4,
    S_ABORT    = 3'd5
  } state_t;

  // The watchdog has already waited 2^TW-2 cycles, so this cycle is the last one allowed.
  localparam logic [TW-1:0] C_WD_LAST = {{(TW-1){1'b1}}, 1'b0};
  localparam logic [TW-1:0] C_WD_ONE  = {{(TW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          cnt_i_q, cnt_i_d;
  logic          clr_q, clr_d;
  logic          step_req_q, step_req_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          timeout;

  // Next-state, watchdog and next-output decode; outputs are decoded from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    wd_d    = '0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = abort ? S_ABORT : S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (abort) begin
          state_d = S_ABORT;
        end else if (step_ack) begin
          state_d = S_ADVANCE;
        end else if (wd_q == C_WD_LAST) begin
          state_d = S_ABORT;
          timeout = 1'b1;
        end else begin
          wd_d = wd_q + C_WD_ONE;
        end
      end
      S_ADVANCE: begin
        if (abort)            state_d = S_ABORT;
        else if (co_i & co_o) state_d = S_FINISH;
        else                  state_d = S_WAIT_ACK;
      end
      S_FINISH: state_d = S_IDLE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    cnt_i_d    = (state_d == S_ADVANCE);
    clr_d      = (state_d == S_CLEAR) || (state_d == S_ABORT);
    step_req_d = (state_d == S_WAIT_ACK);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH);
    err_d      = (state_d == S_ABORT) && timeout;
  end

  // State, watchdog and output registers; reset drops every output at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wd_q       <= '0;
      cnt_i_q    <= 1'b0;
      clr_q      <= 1'b0;
      step_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      cnt_i_q    <= cnt_i_d;
      clr_q      <= clr_d;
      step_req_q <= step_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cnt_i    = cnt_i_q;
  assign clr_i    = clr_q;
  assign clr_o    = clr_q;
  assign step_req = step_req_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  // The outer counter steps on the same edge the inner counter wraps.
  assign cnt_o    = cnt_i_q & co_i;

endmodule
`default_nettype wire

// File: tb/tb_scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_scan_controller
// Purpose  : Directed self-checking bench for scan_controller with behavioural
//            inner/outer counters of selectable width.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_controller;

  localparam int M_NEVER  = 0;
  localparam int M_ALWAYS = 1;
  localparam int M_SLOW   = 2;

  logic clk, rst, start, abort, step_ack;
  logic co_i, co_o;
  logic cnt_i, clr_i, cnt_o, clr_o, step_req, busy, done, err;
  logic [7:0] outs;

  logic [3:0] ci = '0;
  logic [3:0] oc = '0;
  logic [3:0] imask = 4'h7;
  logic [3:0] omask = 4'h7;
  int ni = 3;

  int checks = 0;
  int errors = 0;
  int mode, cyc, age;
  int n_req, n_cnto, cnto_bad, n_done, done_cyc, n_err, err_cyc, err_clr;
  int len_bad, n_acc, seq_bad;
  logic seen_busy;

  scan_controller #(.TW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .step_ack(step_ack),
    .co_i(co_i), .co_o(co_o), .cnt_i(cnt_i), .clr_i(clr_i), .cnt_o(cnt_o),
    .clr_o(clr_o), .step_req(step_req), .busy(busy), .done(done), .err(err)
  );

  assign outs = {cnt_i, clr_i, cnt_o, clr_o, step_req, busy, done, err};
  assign co_i = (ci == imask);
  assign co_o = (oc == omask);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural counters attached to the controller: clear wins over count.
  always @(posedge clk) begin
    if (clr_i)      ci <= '0;
    else if (cnt_i) ci <= (ci + 4'd1) & imask;
    if (clr_o)      oc <= '0;
    else if (cnt_o) oc <= (oc + 4'd1) & omask;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_widths(input int n_in, input int n_out);
    ni    = n_in;
    imask = 4'((1 << n_in) - 1);
    omask = 4'((1 << n_out) - 1);
  endtask

  task automatic clear_stats();
    cyc = 0; age = 0; n_req = 0; n_cnto = 0; cnto_bad = 0; n_done = 0;
    done_cyc = -1; n_err = 0; err_cyc = -1; err_clr = 0; len_bad = 0;
    n_acc = 0; seq_bad = 0;
  endtask

  // One clock: sample outputs after the edge, then drive the ack for the next edge.
  task automatic tick();
    int exp_i, exp_o;
    @(posedge clk);
    #1;
    cyc++;
    if (step_req) n_req++;
    if (cnt_o) begin
      n_cnto++;
      if (ci != imask) cnto_bad++;
    end
    if (done) begin n_done++; done_cyc = cyc; end
    if (err) begin n_err++; err_cyc = cyc; err_clr = int'(clr_i & clr_o); end
    if (step_req) age++;
    else begin
      if (mode == M_SLOW && age != 0 && age != 4) len_bad++;
      age = 0;
    end
    step_ack = (mode == M_ALWAYS) || (mode == M_SLOW && age == 4);
    if (step_req && step_ack) begin
      exp_i = n_acc & int'(imask);
      exp_o = (n_acc >> ni) & int'(omask);
      if (int'(ci) != exp_i || int'(oc) != exp_o) seq_bad++;
      n_acc++;
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; step_ack = 1'b0; mode = M_NEVER;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'(outs), 0);
    rst = 1'b0;
    tick();
    chk("post_release_outs", 32'(outs), 0);

    // Full 3x3-bit scan, ack tied high
    set_widths(3, 3); mode = M_ALWAYS; step_ack = 1'b1; clear_stats();
    start_pulse();
    repeat (134) tick();
    chk("full_req_cycles", n_req, 64);
    chk("full_cnt_o_pulses", n_cnto, 8);
    chk("full_cnt_o_at_inner7", cnto_bad, 0);
    chk("full_done_cycle", done_cyc, 130);
    chk("full_done_count", n_done, 1);
    chk("full_no_err", n_err, 0);
    chk("full_order", seq_bad, 0);
    chk("full_counters", {ci, oc}, 0);
    chk("full_idle", busy, 0);

    // Slow ack, 2x2-bit counters
    set_widths(2, 2); mode = M_SLOW; step_ack = 1'b0; clear_stats();
    start_pulse();
    repeat (90) tick();
    chk("slow_steps", n_acc, 16);
    chk("slow_req_cycles", n_req, 64);
    chk("slow_req_len", len_bad, 0);
    chk("slow_row_major", seq_bad, 0);
    chk("slow_done_cycle", done_cyc, 82);
    chk("slow_done_count", n_done, 1);
    chk("slow_counters", {ci, oc}, 0);

    // Abort at step 10
    set_widths(3, 3); mode = M_ALWAYS; step_ack = 1'b1; clear_stats();
    start_pulse();
    for (int k = 0; k < 100 && n_acc < 10; k++) tick();
    chk("abort_reach_step", n_acc, 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_cycle_outs", 32'({clr_i, clr_o, err, done, busy, step_req}), 32'b110010);
    tick();
    chk("abort_idle", busy, 0);
    chk("abort_counters", {ci, oc}, 0);
    repeat (5) tick();
    chk("abort_no_done", n_done, 0);
    chk("abort_no_err", n_err, 0);

    // Watchdog: ack never comes
    mode = M_NEVER; step_ack = 1'b0; clear_stats();
    start_pulse();
    repeat (25) tick();
    chk("wd_req_cycles", n_req, 15);
    chk("wd_err_count", n_err, 1);
    chk("wd_err_cycle", err_cyc, 17);
    chk("wd_err_with_clear", err_clr, 1);
    chk("wd_no_done", n_done, 0);
    chk("wd_idle", busy, 0);

    // start held through busy and FINISH: only one scan
    set_widths(1, 1); mode = M_ALWAYS; step_ack = 1'b1; clear_stats();
    seen_busy = 1'b0;
    start = 1'b1;
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (busy) seen_busy = 1'b1;
      if (seen_busy && !busy) break;
    end
    start = 1'b0;
    repeat (15) tick();
    chk("hold_seen_busy", seen_busy, 1);
    chk("hold_done_count", n_done, 1);
    chk("hold_done_cycle", done_cyc, 10);
    chk("hold_idle", busy, 0);

    // Asynchronous reset mid WAIT_ACK, then a fresh scan
    set_widths(2, 2); mode = M_SLOW; step_ack = 1'b0; clear_stats();
    start_pulse();
    for (int k = 0; k < 20 && !step_req; k++) tick();
    tick();
    chk("arst_pre_req", step_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_immediate_drop", 32'({busy, step_req}), 0);
    #2 rst = 1'b0;
    tick();
    chk("arst_first_cycle_outs", 32'(outs), 0);
    mode = M_ALWAYS; step_ack = 1'b1; clear_stats();
    start_pulse();
    repeat (40) tick();
    chk("arst_rescan_done_cycle", done_cyc, 34);
    chk("arst_rescan_req", n_req, 16);
    chk("arst_rescan_done_count", n_done, 1);
    chk("arst_rescan_order", seq_bad, 0);
    chk("arst_rescan_counters", {ci, oc}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
